serial_adder: RTL

//   Bit-serial W-bit adder. Computes su = a + b + cin one bit per clock, LSB first,

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_fulladd.sv | 18 +
 rtl/serial_adder.sv | 96 +++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encodings and default width.
package serial_adder_pkg;

  localparam int unsigned DefaultW = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_fulladd.sv
// 1-bit full adder built from two half-adder stages and an OR of their carries.
module serial_adder_fulladd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic su,
  output logic ca
);

  logic ha0_s, ha0_c, ha1_c;

  assign ha0_s = a ^ b;
  assign ha0_c = a & b;
  assign su    = ha0_s ^ cin;
  assign ha1_c = ha0_s & cin;
  assign ca    = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one full-adder cell plus a carry flop, LSB first,
// with a start/busy/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] su,
  output logic         ca
);

  localparam int unsigned CntW = $clog2(W);
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  state_e state_q, state_d;

  logic [CntW-1:0] cnt_q;
  logic [W-1:0]    sa_q, sb_q, su_q;
  logic            carry_q, ca_q;
  logic            fa_s, fa_c;

  serial_adder_fulladd u_fulladd (
    .a   (sa_q[0]),
    .b   (sb_q[0]),
    .cin (carry_q),
    .su  (fa_s),
    .ca  (fa_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (cnt_q == CntLast) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  // su/ca are not cleared on load so the previous result holds until shifting starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      su_q    <= '0;
      carry_q <= 1'b0;
      ca_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          su_q    <= {fa_s, su_q[W-1:1]};
          carry_q <= fa_c;
          sa_q    <= {1'b0, sa_q[W-1:1]};
          sb_q    <= {1'b0, sb_q[W-1:1]};
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CntLast) ca_q <= fa_c;
        end
        default: ;
      endcase
    end
  end

  assign su = su_q;
  assign ca = ca_q;

endmodule
